// File: rtl/clk_div_pkg.sv
// Shared types and limits for the clock divider and its receive-side detector.
package clk_div_pkg;
  typedef enum logic [1:0] {IDLE, ACQ, MEAS, LOCK} state_t;

  localparam int CNT_W_DEF = 32;
  localparam int DIV_MIN   = 2;
  localparam int DIV_MAX   = 32;
  localparam int MATCH_W   = 4;
endpackage

// File: rtl/clk_div_detect_if.sv
// Enable/sample input and measurement results of the divided-clock detector.
interface clk_div_detect_if import clk_div_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
);
  logic             en;
  logic             clk_in;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             locked;
  logic [CNT_W-1:0] div_out;
  logic             stuck;

  modport master (output en, clk_in, input period, period_vld, locked, div_out, stuck);
  modport slave  (input en, clk_in, output period, period_vld, locked, div_out, stuck);
endinterface

// File: rtl/clk_div_detect_edge_sync.sv
// Synchronizes a slow clock or strobe into clki and flags its rising edges.
module clk_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clki,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   q_d;

  always_ff @(posedge clki or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      q_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      q_d  <= sync[SYNC_STAGES-1];
    end
  end

  assign q    = sync[SYNC_STAGES-1];
  assign rise = q & ~q_d;
endmodule

// File: rtl/clk_div_detect.sv
// Measures rising-edge spacing of clk_in in clki cycles, locks on LOCK_CNT
// equal periods and flags a stopped or static clk_in.
module clk_div_detect import clk_div_pkg::*; #(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clki,
  input  logic             rst,
  clk_div_detect_if.slave  bus
);
  localparam logic [CNT_W-1:0]   TMO    = CNT_W'(TIMEOUT);
  localparam logic [MATCH_W-1:0] M_LOCK = MATCH_W'(LOCK_CNT - 1);

  logic rise, clk_q, unused_sync;

  clk_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clki(clki), .rst(rst), .d(bus.clk_in), .q(clk_q), .rise(rise)
  );
  assign unused_sync = clk_q;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx, wcnt, wcnt_nx;
  logic [CNT_W-1:0]   period_q, period_nx, div_q, div_nx;
  logic [MATCH_W-1:0] match_cnt, match_nx;
  logic               ref_vld, ref_nx, vld_q, vld_nx;
  logic               locked_q, locked_nx, stuck_q, stuck_nx, same;

  // ref_vld keeps the first period after acquisition from matching a stale register
  assign same = ref_vld && (cnt == period_q);

  always_ff @(posedge clki or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wcnt      <= '0;
      period_q  <= '0;
      div_q     <= '0;
      match_cnt <= '0;
      ref_vld   <= 1'b0;
      vld_q     <= 1'b0;
      locked_q  <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      wcnt      <= wcnt_nx;
      period_q  <= period_nx;
      div_q     <= div_nx;
      match_cnt <= match_nx;
      ref_vld   <= ref_nx;
      vld_q     <= vld_nx;
      locked_q  <= locked_nx;
      stuck_q   <= stuck_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    wcnt_nx   = wcnt;
    period_nx = period_q;
    div_nx    = div_q;
    match_nx  = match_cnt;
    ref_nx    = ref_vld;
    vld_nx    = 1'b0;
    locked_nx = locked_q;
    stuck_nx  = stuck_q;
    if (!bus.en) begin
      state_nx  = IDLE;
      cnt_nx    = '0;
      wcnt_nx   = '0;
      period_nx = '0;
      div_nx    = '0;
      match_nx  = '0;
      ref_nx    = 1'b0;
      locked_nx = 1'b0;
      stuck_nx  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = ACQ;
          wcnt_nx  = '0;
        end
        ACQ: begin
          if (rise) begin
            state_nx = MEAS;
            cnt_nx   = CNT_W'(1);
            wcnt_nx  = '0;
            stuck_nx = 1'b0;
            ref_nx   = 1'b0;
          end else if (wcnt >= TMO - 1'b1) begin
            stuck_nx  = 1'b1;
            wcnt_nx   = '0;
            cnt_nx    = '0;
            match_nx  = '0;
            locked_nx = 1'b0;
            div_nx    = '0;
          end else begin
            wcnt_nx = wcnt + 1'b1;
          end
        end
        MEAS, LOCK: begin
          // a rise in the timeout cycle is still a valid period
          if (rise) begin
            period_nx = cnt;
            vld_nx    = 1'b1;
            cnt_nx    = CNT_W'(1);
            stuck_nx  = 1'b0;
            ref_nx    = 1'b1;
            if (same) begin
              if (state == MEAS) begin
                match_nx = match_cnt + 1'b1;
                if (match_nx == M_LOCK) begin
                  locked_nx = 1'b1;
                  div_nx    = cnt;
                  state_nx  = LOCK;
                end
              end
            end else begin
              match_nx  = '0;
              locked_nx = 1'b0;
              div_nx    = '0;
              state_nx  = MEAS;
            end
          end else if (cnt >= TMO) begin
            state_nx  = ACQ;
            stuck_nx  = 1'b1;
            locked_nx = 1'b0;
            div_nx    = '0;
            match_nx  = '0;
            cnt_nx    = '0;
            wcnt_nx   = '0;
            ref_nx    = 1'b0;
          end else if (cnt != '1) begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign bus.period     = period_q;
  assign bus.period_vld = vld_q;
  assign bus.locked     = locked_q;
  assign bus.div_out    = div_q;
  assign bus.stuck      = stuck_q;
endmodule
